// File: rtl/conv_ram_pkg.sv
// Shared types and default sizes for the two-requester RAM arbiter.
// Requester ids double as round-robin pointer values.
package conv_ram_pkg;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

endpackage

// File: rtl/conv_ram_arbiter_rr.sv
// rr_arbiter2: 2-way round-robin arbiter with a registered priority pointer.
// After a grant the pointer names the requester that lost (or did not ask).
module rr_arbiter2
  import conv_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  req_id_t    r_ptr;
  logic [1:0] w_gnt;

  // Grants are held off while reset is active so nothing is launched into reset.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst) begin
      if (i_req == 2'b11) begin
        w_gnt = (r_ptr == REQ1) ? 2'b10 : 2'b01;
      end else begin
        w_gnt = i_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= REQ0;
    end else if (w_gnt[0]) begin
      r_ptr <= REQ1;
    end else if (w_gnt[1]) begin
      r_ptr <= REQ0;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/conv_ram_arbiter.sv
// Two requesters sharing a simple dual-port RAM: independent round-robin
// arbitration for the write port and the read port, 1-cycle read return.
module conv_ram_arbiter
  import conv_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  ram_write_en_o,
  output logic [ADDR_WIDTH-1:0] ram_write_addr_o,
  output logic [DATA_WIDTH-1:0] ram_write_data_o,
  output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_read_data_i
);

  logic [1:0] w_wr_req;
  logic [1:0] w_rd_req;
  logic [1:0] w_wr_gnt;
  logic [1:0] w_rd_gnt;
  logic       r_rd_valid;
  req_id_t    r_rd_id;

  assign w_wr_req = {req1_i & we1_i, req0_i & we0_i};
  assign w_rd_req = {req1_i & ~we1_i, req0_i & ~we0_i};

  rr_arbiter2 u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_wr_req),
    .o_gnt (w_wr_gnt)
  );

  rr_arbiter2 u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_rd_req),
    .o_gnt (w_rd_gnt)
  );

  assign gnt0_o = w_wr_gnt[0] | w_rd_gnt[0];
  assign gnt1_o = w_wr_gnt[1] | w_rd_gnt[1];

  always_comb begin
    ram_write_en_o   = 1'b0;
    ram_write_addr_o = '0;
    ram_write_data_o = '0;
    if (w_wr_gnt[0]) begin
      ram_write_en_o   = 1'b1;
      ram_write_addr_o = addr0_i;
      ram_write_data_o = wdata0_i;
    end else if (w_wr_gnt[1]) begin
      ram_write_en_o   = 1'b1;
      ram_write_addr_o = addr1_i;
      ram_write_data_o = wdata1_i;
    end
  end

  always_comb begin
    ram_read_addr_o = '0;
    if (w_rd_gnt[0]) begin
      ram_read_addr_o = addr0_i;
    end else if (w_rd_gnt[1]) begin
      ram_read_addr_o = addr1_i;
    end
  end

  // Tags the read in flight so the RAM's registered output is steered to its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_id    <= REQ0;
    end else begin
      r_rd_valid <= |w_rd_gnt;
      r_rd_id    <= w_rd_gnt[1] ? REQ1 : REQ0;
    end
  end

  assign rvalid0_o = r_rd_valid && (r_rd_id == REQ0);
  assign rvalid1_o = r_rd_valid && (r_rd_id == REQ1);
  assign rdata0_o  = rvalid0_o ? ram_read_data_i : '0;
  assign rdata1_o  = rvalid1_o ? ram_read_data_i : '0;

endmodule

// File: tb/tb_conv_ram_arbiter.sv
// Bench for conv_ram_arbiter: behavioural RAM, a rule-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_conv_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NW = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_i = 1'b0, req1_i = 1'b0, we0_i = 1'b0, we1_i = 1'b0;
  logic [AW-1:0] addr0_i = '0, addr1_i = '0;
  logic [DW-1:0] wdata0_i = '0, wdata1_i = '0;
  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [DW-1:0] rdata0_o, rdata1_o;
  logic          ram_write_en_o;
  logic [AW-1:0] ram_write_addr_o, ram_read_addr_o;
  logic [DW-1:0] ram_write_data_o;
  logic [DW-1:0] ram_rd_q;

  always #5 clk = ~clk;

  conv_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .req0_i           (req0_i),
    .req1_i           (req1_i),
    .we0_i            (we0_i),
    .we1_i            (we1_i),
    .addr0_i          (addr0_i),
    .addr1_i          (addr1_i),
    .wdata0_i         (wdata0_i),
    .wdata1_i         (wdata1_i),
    .gnt0_o           (gnt0_o),
    .gnt1_o           (gnt1_o),
    .rvalid0_o        (rvalid0_o),
    .rvalid1_o        (rvalid1_o),
    .rdata0_o         (rdata0_o),
    .rdata1_o         (rdata1_o),
    .ram_write_en_o   (ram_write_en_o),
    .ram_write_addr_o (ram_write_addr_o),
    .ram_write_data_o (ram_write_data_o),
    .ram_read_addr_o  (ram_read_addr_o),
    .ram_read_data_i  (ram_rd_q)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'((i * 17 + 3) & 255);
  endfunction

  // Behavioural RAM: registered read of pre-write contents; reloaded during reset.
  logic [DW-1:0] ram [NW];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) ram[i] <= init_val(i);
      ram_rd_q <= '0;
    end else begin
      ram_rd_q <= ram[ram_read_addr_o];
      if (ram_write_en_o) ram[ram_write_addr_o] <= ram_write_data_o;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model state
  int            m_wptr, m_rptr;
  logic [DW-1:0] m_mem [NW];
  bit            m_pv;
  int            m_pid;
  logic [DW-1:0] m_pdata;

  function automatic void model_reset();
    m_wptr = 0;
    m_rptr = 0;
    m_pv   = 1'b0;
    m_pid  = 0;
    m_pdata = '0;
    for (int i = 0; i < NW; i++) m_mem[i] = init_val(i);
  endfunction

  // Winner of one class: a lone requester always wins, a tie goes to the pointer.
  function automatic int pick(input bit a, input bit b, input int ptr);
    if (a && b) return ptr;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  logic          s_gnt0, s_gnt1, s_wen, s_rv0, s_rv1;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [DW-1:0] s_wdata, s_rd0, s_rd1;

  task automatic do_cycle(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int wg, rg;
    logic [AW-1:0] ea_w, ea_r;
    logic [DW-1:0] ed_w;
    @(posedge clk); #1;
    req0_i = r0; we0_i = w0; addr0_i = a0; wdata0_i = d0;
    req1_i = r1; we1_i = w1; addr1_i = a1; wdata1_i = d1;
    @(negedge clk);
    wg = pick(r0 && w0, r1 && w1, m_wptr);
    rg = pick(r0 && !w0, r1 && !w1, m_rptr);
    ea_w = (wg == 0) ? a0 : (wg == 1) ? a1 : '0;
    ed_w = (wg == 0) ? d0 : (wg == 1) ? d1 : '0;
    ea_r = (rg == 0) ? a0 : (rg == 1) ? a1 : '0;
    s_gnt0 = gnt0_o; s_gnt1 = gnt1_o; s_wen = ram_write_en_o;
    s_waddr = ram_write_addr_o; s_wdata = ram_write_data_o; s_raddr = ram_read_addr_o;
    s_rv0 = rvalid0_o; s_rv1 = rvalid1_o; s_rd0 = rdata0_o; s_rd1 = rdata1_o;
    check("gnt0", 32'(gnt0_o), 32'(wg == 0 || rg == 0));
    check("gnt1", 32'(gnt1_o), 32'(wg == 1 || rg == 1));
    check("wr_en", 32'(ram_write_en_o), 32'(wg >= 0));
    check("wr_addr", 32'(ram_write_addr_o), 32'(ea_w));
    check("wr_data", 32'(ram_write_data_o), 32'(ed_w));
    check("rd_addr", 32'(ram_read_addr_o), 32'(ea_r));
    check("rvalid0", 32'(rvalid0_o), 32'(m_pv && m_pid == 0));
    check("rvalid1", 32'(rvalid1_o), 32'(m_pv && m_pid == 1));
    check("rdata0", 32'(rdata0_o), (m_pv && m_pid == 0) ? 32'(m_pdata) : 32'd0);
    check("rdata1", 32'(rdata1_o), (m_pv && m_pid == 1) ? 32'(m_pdata) : 32'd0);
    m_pv  = (rg >= 0);
    m_pid = rg;
    if (rg >= 0) m_pdata = m_mem[ea_r];
    if (wg >= 0) begin
      m_mem[ea_w] = ed_w;
      m_wptr = 1 - wg;
    end
    if (rg >= 0) m_rptr = 1 - rg;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    req0_i = 1'b1; we0_i = 1'b0; addr0_i = 4'd9;
    req1_i = 1'b1; we1_i = 1'b1; addr1_i = 4'd9; wdata1_i = 8'hEE;
    @(negedge clk);
    check("rst_gnt0", 32'(gnt0_o), 32'd0);
    check("rst_gnt1", 32'(gnt1_o), 32'd0);
    check("rst_wr_en", 32'(ram_write_en_o), 32'd0);
    check("rst_rvalid", 32'({rvalid1_o, rvalid0_o}), 32'd0);
    check("rst_rdata", 32'({rdata1_o, rdata0_o}), 32'd0);
    check("rst_wr_ptr", 32'(u_dut.u_wr_arb.r_ptr), 32'd0);
    check("rst_rd_ptr", 32'(u_dut.u_rd_arb.r_ptr), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    req0_i = 1'b0; req1_i = 1'b0; we0_i = 1'b0; we1_i = 1'b0;
    model_reset();
  endtask

  bit            h_r0, h_w0, h_r1, h_w1;
  logic [AW-1:0] h_a0, h_a1;
  logic [DW-1:0] h_d0, h_d1;

  initial begin
    model_reset();
    do_reset(2);

    // Lone write from requester 0
    do_cycle(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
    check("w_gnt0", 32'(s_gnt0), 32'd1);
    check("w_en", 32'(s_wen), 32'd1);
    check("w_addr", 32'(s_waddr), 32'd3);
    check("w_data", 32'(s_wdata), 32'hA5);

    // Two competing writes from reset
    do_reset(1);
    do_cycle(1, 1, 4'd1, 8'h10, 1, 1, 4'd2, 8'h20);
    check("ww_c1_gnt", 32'({s_gnt1, s_gnt0}), 32'b01);
    do_cycle(1, 1, 4'd1, 8'h10, 1, 1, 4'd2, 8'h20);
    check("ww_c2_gnt", 32'({s_gnt1, s_gnt0}), 32'b10);
    check("ww_c2_addr", 32'(s_waddr), 32'd2);

    // Same-address read and write in one cycle returns the old word
    do_cycle(1, 1, 4'd5, 8'h11, 0, 0, 4'd0, 8'h00);
    do_cycle(1, 0, 4'd5, 8'h00, 1, 1, 4'd5, 8'h3C);
    check("rw_gnt", 32'({s_gnt1, s_gnt0}), 32'b11);
    do_cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    check("rw_rvalid0", 32'(s_rv0), 32'd1);
    check("rw_rdata0", 32'(s_rd0), 32'h11);
    do_cycle(0, 0, 4'd0, 8'h00, 1, 0, 4'd5, 8'h00);
    do_cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    check("rw_new_rdata1", 32'(s_rd1), 32'h3C);

    // Continuous competing reads alternate and return back-to-back
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) do_cycle(1, 0, 4'd6, 8'h00, 1, 0, 4'd7, 8'h00);
      else       do_cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
      if (k < 4) check("rr_gnt", 32'({s_gnt1, s_gnt0}), (k % 2 == 0) ? 32'b01 : 32'b10);
      if (k >= 1) begin
        check("rr_rvalid", 32'({s_rv1, s_rv0}), (k % 2 == 1) ? 32'b01 : 32'b10);
        check("rr_rdata", 32'(s_rd0 | s_rd1), (k % 2 == 1) ? 32'h69 : 32'h7A);
      end
    end

    // Reset lands on a cycle with a read grant to requester 1
    do_reset(1);
    do_cycle(1, 1, 4'd4, 8'h44, 1, 0, 4'd8, 8'h00);
    @(posedge clk); #1;
    req0_i = 1'b0; req1_i = 1'b1; we1_i = 1'b0; addr1_i = 4'd2;
    @(negedge clk);
    check("rst_mid_gnt1", 32'(gnt1_o), 32'd1);
    check("rst_mid_rvalid1", 32'(rvalid1_o), 32'd1);
    check("rst_mid_rdata1", 32'(rdata1_o), 32'(init_val(8)));
    #1 rst = 1'b1;
    @(posedge clk); #1;
    req1_i = 1'b0;
    rst = 1'b0;
    model_reset();
    check("rst_rel_wr_ptr", 32'(u_dut.u_wr_arb.r_ptr), 32'd0);
    check("rst_rel_rd_ptr", 32'(u_dut.u_rd_arb.r_ptr), 32'd0);
    for (int k = 0; k < 2; k++) begin
      do_cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
      check("rst_rel_rvalid1", 32'(s_rv1), 32'd0);
    end

    // Randomised traffic; ungranted requests usually persist
    h_r0 = 0; h_r1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(h_r0 && !s_gnt0 && $urandom_range(3) != 0)) begin
        h_r0 = ($urandom_range(3) != 0); h_w0 = $urandom_range(1) == 1;
        h_a0 = AW'($urandom_range(NW - 1)); h_d0 = DW'($urandom);
      end
      if (!(h_r1 && !s_gnt1 && $urandom_range(3) != 0)) begin
        h_r1 = ($urandom_range(3) != 0); h_w1 = $urandom_range(1) == 1;
        h_a1 = AW'($urandom_range(NW - 1)); h_d1 = DW'($urandom);
      end
      do_cycle(h_r0, h_w0, h_a0, h_d0, h_r1, h_w1, h_a1, h_d1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
